// File: rtl/ahb_bus_matrix_core_if.sv
// Bundled AHB-Lite bus for the matrix core: flat per-master and per-slave vectors.
// The slave modport is the core's view; the master modport is the surrounding masters and slaves.
interface ahb_bus_matrix_core_if #(
  parameter int SNUM = 8,
  parameter int MNUM = 8
);
  logic [MNUM*32-1:0]   im_haddr;
  logic [MNUM*32-1:0]   im_hwdata;
  logic [MNUM*2-1:0]    im_htrans;
  logic [MNUM-1:0]      im_hwrite;
  logic [MNUM*3-1:0]    im_hsize;
  logic [MNUM*3-1:0]    im_hburst;
  logic [MNUM*4-1:0]    im_hprot;
  logic [MNUM*SNUM-1:0] im_route;
  logic [MNUM*32-1:0]   om_hrdata;
  logic [MNUM-1:0]      om_hready;
  logic [MNUM*2-1:0]    om_hresp;
  logic [SNUM*32-1:0]   os_haddr;
  logic [SNUM*32-1:0]   os_hwdata;
  logic [SNUM*2-1:0]    os_htrans;
  logic [SNUM-1:0]      os_hwrite;
  logic [SNUM-1:0]      os_hsel;
  logic [SNUM*3-1:0]    os_hsize;
  logic [SNUM*3-1:0]    os_hburst;
  logic [SNUM*4-1:0]    os_hprot;
  logic [SNUM*32-1:0]   is_hrdata;
  logic [SNUM-1:0]      is_hready;
  logic [SNUM*2-1:0]    is_hresp;

  modport slave (
    input  im_haddr, im_hwdata, im_htrans, im_hwrite, im_hsize, im_hburst, im_hprot, im_route,
    input  is_hrdata, is_hready, is_hresp,
    output om_hrdata, om_hready, om_hresp,
    output os_haddr, os_hwdata, os_htrans, os_hwrite, os_hsel, os_hsize, os_hburst, os_hprot
  );

  modport master (
    output im_haddr, im_hwdata, im_htrans, im_hwrite, im_hsize, im_hburst, im_hprot, im_route,
    output is_hrdata, is_hready, is_hresp,
    input  om_hrdata, om_hready, om_hresp,
    input  os_haddr, os_hwdata, os_htrans, os_hwrite, os_hsel, os_hsize, os_hburst, os_hprot
  );
endinterface

// File: rtl/ahb_bus_matrix_core.sv
// AHB-Lite bus matrix: per-master address decode, per-port fixed-priority arbitration with
// burst lock, combinational address path, and an internal default slave at port index SNUM.
module ahb_bus_matrix_core #(
  parameter int          SNUM        = 8,
  parameter int          MNUM        = 8,
  parameter logic [31:0] SLV0_BASE   = 32'h0, SLV1_BASE  = 32'h0, SLV2_BASE  = 32'h0, SLV3_BASE  = 32'h0,
  parameter logic [31:0] SLV4_BASE   = 32'h0, SLV5_BASE  = 32'h0, SLV6_BASE  = 32'h0, SLV7_BASE  = 32'h0,
  parameter logic [31:0] SLV8_BASE   = 32'h0, SLV9_BASE  = 32'h0, SLV10_BASE = 32'h0, SLV11_BASE = 32'h0,
  parameter logic [31:0] SLV12_BASE  = 32'h0, SLV13_BASE = 32'h0, SLV14_BASE = 32'h0, SLV15_BASE = 32'h0,
  parameter logic [31:0] SLV0_MASK   = 32'h0, SLV1_MASK  = 32'h0, SLV2_MASK  = 32'h0, SLV3_MASK  = 32'h0,
  parameter logic [31:0] SLV4_MASK   = 32'h0, SLV5_MASK  = 32'h0, SLV6_MASK  = 32'h0, SLV7_MASK  = 32'h0,
  parameter logic [31:0] SLV8_MASK   = 32'h0, SLV9_MASK  = 32'h0, SLV10_MASK = 32'h0, SLV11_MASK = 32'h0,
  parameter logic [31:0] SLV12_MASK  = 32'h0, SLV13_MASK = 32'h0, SLV14_MASK = 32'h0, SLV15_MASK = 32'h0
) (
  input  logic                 hclk,
  input  logic                 hreset,
  ahb_bus_matrix_core_if.slave bus
);
  localparam int NP = SNUM + 1;
  localparam logic [1:0] HT_BUSY = 2'b01;
  localparam logic [1:0] HT_SEQ  = 2'b11;
  localparam logic [15:0][31:0] BASE = {SLV15_BASE, SLV14_BASE, SLV13_BASE, SLV12_BASE, SLV11_BASE,
    SLV10_BASE, SLV9_BASE, SLV8_BASE, SLV7_BASE, SLV6_BASE, SLV5_BASE, SLV4_BASE, SLV3_BASE,
    SLV2_BASE, SLV1_BASE, SLV0_BASE};
  localparam logic [15:0][31:0] MASK = {SLV15_MASK, SLV14_MASK, SLV13_MASK, SLV12_MASK, SLV11_MASK,
    SLV10_MASK, SLV9_MASK, SLV8_MASK, SLV7_MASK, SLV6_MASK, SLV5_MASK, SLV4_MASK, SLV3_MASK,
    SLV2_MASK, SLV1_MASK, SLV0_MASK};

  typedef logic [4:0] port_t;
  typedef logic [3:0] mst_t;
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_e;

  // Windows must be disjoint and each mask a run of ones from the MSB down.
  function automatic bit cfg_ok();
    bit ok = 1'b1;
    for (int a = 0; a < SNUM; a++) begin
      if (((~MASK[a]) & ((~MASK[a]) + 32'd1)) != 32'h0) ok = 1'b0;
      for (int b = a + 1; b < SNUM; b++)
        if (((BASE[a] ^ BASE[b]) & MASK[a] & MASK[b]) == 32'h0) ok = 1'b0;
    end
    return ok;
  endfunction
  localparam bit CFG_OK = cfg_ok();

  cfg_legal_a: assert property (@(posedge hclk) CFG_OK)
    else $fatal(1, "ahb_bus_matrix_core: overlapping slave windows or non-contiguous mask");

  logic [NP-1:0]   p_hready;
  logic [31:0]     p_rdata [NP];
  logic [1:0]      p_resp  [NP];
  port_t           dec_port [MNUM];
  logic [MNUM-1:0] dph_ready, req, acc, stall;
  port_t           acc_port [MNUM];
  logic [NP-1:0]   gnt_v;
  mst_t            gnt_m [NP];
  logic            def_start;

  logic [MNUM-1:0] dph_v_q, dph_v_d;
  port_t           dph_p_q [MNUM];
  port_t           dph_p_d [MNUM];
  logic [NP-1:0]   down_v_q, down_v_d;
  mst_t            down_m_q [NP];
  mst_t            down_m_d [NP];
  ds_e             ds_q;
  logic            def_hready_q;
  logic [1:0]      def_hresp_q;

  always_comb begin
    for (int s = 0; s < SNUM; s++) begin
      p_hready[s] = bus.is_hready[s];
      p_rdata[s]  = bus.is_hrdata[32*s +: 32];
      p_resp[s]   = bus.is_hresp[2*s +: 2];
    end
    p_hready[SNUM] = def_hready_q;
    p_rdata[SNUM]  = '0;
    p_resp[SNUM]   = def_hresp_q;
  end

  // Descending scan so the lowest matching slave index is the last one written.
  always_comb begin
    for (int m = 0; m < MNUM; m++) begin
      dec_port[m] = port_t'(SNUM);
      for (int s = SNUM - 1; s >= 0; s--)
        if ((((bus.im_haddr[32*m +: 32] ^ BASE[s]) & MASK[s]) == 32'h0) && bus.im_route[m*SNUM + s])
          dec_port[m] = port_t'(s);
      dph_ready[m] = !dph_v_q[m] || p_hready[int'(dph_p_q[m])];
      req[m]       = !hreset && bus.im_htrans[2*m + 1] && dph_ready[m];
    end
  end

  always_comb begin
    int         om;
    logic [1:0] otr;
    logic       lock;
    for (int p = 0; p < NP; p++) begin
      // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
      gnt_v[p] = 1'b0;
      gnt_m[p] = '0;
      om       = int'(down_m_q[p]);
      otr      = bus.im_htrans[2*om +: 2];
      lock     = !hreset && down_v_q[p] && (otr == HT_SEQ || otr == HT_BUSY) &&
                 (dec_port[om] == port_t'(p));
      if (lock) begin
        gnt_v[p] = dph_ready[om];
        gnt_m[p] = down_m_q[p];
      end else begin
        for (int m = MNUM - 1; m >= 0; m--)
          if (req[m] && dec_port[m] == port_t'(p)) begin
            gnt_v[p] = 1'b1;
            gnt_m[p] = mst_t'(m);
          end
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int m = 0; m < MNUM; m++) acc_port[m] = port_t'(SNUM);
    for (int p = 0; p < NP; p++)
      if (gnt_v[p] && p_hready[p]) begin
        acc[int'(gnt_m[p])]      = 1'b1;
        acc_port[int'(gnt_m[p])] = port_t'(p);
      end
    for (int m = 0; m < MNUM; m++) begin
      stall[m]   = req[m] && !(gnt_v[int'(dec_port[m])] && gnt_m[int'(dec_port[m])] == mst_t'(m) &&
                               p_hready[int'(dec_port[m])]);
      dph_v_d[m] = dph_ready[m] ? acc[m] : dph_v_q[m];
      dph_p_d[m] = dph_ready[m] ? acc_port[m] : dph_p_q[m];
    end
    for (int p = 0; p < NP; p++) begin
      down_v_d[p] = p_hready[p] ? gnt_v[p] : down_v_q[p];
      down_m_d[p] = p_hready[p] ? gnt_m[p] : down_m_q[p];
    end
    def_start = gnt_v[SNUM] && p_hready[SNUM] && bus.im_htrans[2*int'(gnt_m[SNUM]) + 1];
  end

  always_comb begin
    int g;
    bus.os_haddr  = '0;
    bus.os_hwdata = '0;
    bus.os_htrans = '0;
    bus.os_hwrite = '0;
    bus.os_hsel   = '0;
    bus.os_hsize  = '0;
    bus.os_hburst = '0;
    bus.os_hprot  = '0;
    for (int s = 0; s < SNUM; s++) begin
      g = int'(gnt_m[s]);
      if (gnt_v[s]) begin
        bus.os_hsel[s]             = 1'b1;
        bus.os_haddr[32*s +: 32]   = bus.im_haddr[32*g +: 32];
        bus.os_htrans[2*s +: 2]    = bus.im_htrans[2*g +: 2];
        bus.os_hwrite[s]           = bus.im_hwrite[g];
        bus.os_hsize[3*s +: 3]     = bus.im_hsize[3*g +: 3];
        bus.os_hburst[3*s +: 3]    = bus.im_hburst[3*g +: 3];
        bus.os_hprot[4*s +: 4]     = bus.im_hprot[4*g +: 4];
      end
      if (!hreset && down_v_q[s])
        bus.os_hwdata[32*s +: 32] = bus.im_hwdata[32*int'(down_m_q[s]) +: 32];
    end
    bus.om_hrdata = '0;
    bus.om_hresp  = '0;
    for (int m = 0; m < MNUM; m++) begin
      bus.om_hready[m] = hreset || (dph_ready[m] && !stall[m]);
      if (!hreset && dph_v_q[m]) begin
        bus.om_hrdata[32*m +: 32] = p_rdata[int'(dph_p_q[m])];
        bus.om_hresp[2*m +: 2]    = p_resp[int'(dph_p_q[m])];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      dph_v_q  <= '0;
      down_v_q <= '0;
      for (int m = 0; m < MNUM; m++) dph_p_q[m] <= '0;
      for (int p = 0; p < NP; p++) down_m_q[p] <= '0;
    end else begin
      dph_v_q  <= dph_v_d;
      down_v_q <= down_v_d;
      for (int m = 0; m < MNUM; m++) dph_p_q[m] <= dph_p_d[m];
      for (int p = 0; p < NP; p++) down_m_q[p] <= down_m_d[p];
    end
  end

  // Default slave: OKAY for IDLE/BUSY, two-cycle ERROR for any real transfer.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      ds_q         <= DS_IDLE;
      def_hready_q <= 1'b1;
      def_hresp_q  <= 2'b00;
    end else if (ds_q == DS_ERR1) begin
      ds_q         <= DS_ERR2;
      def_hready_q <= 1'b1;
      def_hresp_q  <= 2'b01;
    end else if (def_start) begin
      ds_q         <= DS_ERR1;
      def_hready_q <= 1'b0;
      def_hresp_q  <= 2'b01;
    end else begin
      ds_q         <= DS_IDLE;
      def_hready_q <= 1'b1;
      def_hresp_q  <= 2'b00;
    end
  end
endmodule

// File: tb/tb_ahb_bus_matrix_core.sv
// Directed bench for a 2x2 matrix: slave0 at 0x0xxx_xxxx, slave1 at 0x1xxx_xxxx.
module tb_ahb_bus_matrix_core;
  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;

  logic hclk = 1'b0;
  logic hreset;
  int   n_chk  = 0;
  int   n_pass = 0;

  ahb_bus_matrix_core_if #(.SNUM(2), .MNUM(2)) bus ();

  ahb_bus_matrix_core #(
    .SNUM(2), .MNUM(2),
    .SLV0_BASE(32'h0000_0000), .SLV0_MASK(32'hF000_0000),
    .SLV1_BASE(32'h1000_0000), .SLV1_MASK(32'hF000_0000)
  ) dut (
    .hclk  (hclk),
    .hreset(hreset),
    .bus   (bus)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change 1ns after the rising edge; checks run 2ns later, well before the next edge.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input int m, input logic [1:0] tr, input logic [31:0] addr, input logic wr);
    bus.im_htrans[2*m +: 2]  = tr;
    bus.im_haddr[32*m +: 32] = addr;
    bus.im_hwrite[m]         = wr;
    bus.im_hsize[3*m +: 3]   = 3'b010;
    bus.im_hburst[3*m +: 3]  = 3'b001;
    bus.im_hprot[4*m +: 4]   = 4'b0011;
  endtask

  initial begin
    hreset        = 1'b1;
    bus.im_haddr  = '0;
    bus.im_hwdata = '0;
    bus.im_htrans = '0;
    bus.im_hwrite = '0;
    bus.im_hsize  = '0;
    bus.im_hburst = '0;
    bus.im_hprot  = '0;
    bus.im_route  = 4'b1111;
    bus.is_hrdata = '0;
    bus.is_hready = 2'b11;
    bus.is_hresp  = '0;

    // Reset state
    tick(); tick(); settle();
    check("rst_om_hready", {30'b0, bus.om_hready}, 32'h3);
    check("rst_om_hresp",  {28'b0, bus.om_hresp}, 32'h0);
    check("rst_os_hsel",   {30'b0, bus.os_hsel}, 32'h0);
    check("rst_os_htrans", {28'b0, bus.os_htrans}, 32'h0);
    check("rst_os_haddr0", bus.os_haddr[31:0], 32'h0);
    tick(); hreset = 1'b0;

    // Write to slave1: address forwarded this cycle, write data next cycle
    tick(); drive(0, NSEQ, 32'h1000_0004, 1'b1); settle();
    check("wr_os_hsel",   {30'b0, bus.os_hsel}, 32'h2);
    check("wr_os_haddr1", bus.os_haddr[63:32], 32'h1000_0004);
    check("wr_os_htrans1", {30'b0, bus.os_htrans[3:2]}, 32'h2);
    check("wr_os_hwrite1", {31'b0, bus.os_hwrite[1]}, 32'h1);
    check("wr_om_hready0_a", {31'b0, bus.om_hready[0]}, 32'h1);
    tick(); drive(0, IDLE, 32'h0, 1'b0); bus.im_hwdata[31:0] = 32'hA5A5_A5A5; settle();
    check("wr_os_hwdata1", bus.os_hwdata[63:32], 32'hA5A5_A5A5);
    check("wr_os_hwdata0", bus.os_hwdata[31:0], 32'h0);
    check("wr_om_hready0_d", {31'b0, bus.om_hready[0]}, 32'h1);
    check("wr_os_hsel_d", {30'b0, bus.os_hsel}, 32'h0);

    // Both masters to slave0: master0 wins, master1 waits one cycle
    tick(); bus.im_hwdata = '0; drive(0, NSEQ, 32'h0000_0020, 1'b0); drive(1, NSEQ, 32'h0000_0030, 1'b0); settle();
    check("arb_os_haddr0_a", bus.os_haddr[31:0], 32'h0000_0020);
    check("arb_om_hready_a", {30'b0, bus.om_hready}, 32'h1);
    tick(); drive(0, IDLE, 32'h0, 1'b0); bus.is_hrdata[31:0] = 32'hCAFE_F00D; settle();
    check("arb_os_haddr0_b", bus.os_haddr[31:0], 32'h0000_0030);
    check("arb_om_hready_b", {30'b0, bus.om_hready}, 32'h3);
    check("arb_om_hrdata0", bus.om_hrdata[31:0], 32'hCAFE_F00D);
    check("arb_om_hrdata1_idle", bus.om_hrdata[63:32], 32'h0);
    tick(); drive(1, IDLE, 32'h0, 1'b0); bus.is_hrdata[31:0] = 32'h1234_5678; settle();
    check("arb_om_hrdata1", bus.om_hrdata[63:32], 32'h1234_5678);
    check("arb_om_hready1_d", {31'b0, bus.om_hready[1]}, 32'h1);
    check("arb_om_hrdata0_done", bus.om_hrdata[31:0], 32'h0);

    // Unmapped address goes to the default slave: two-cycle ERROR
    tick(); bus.is_hrdata = '0; drive(1, NSEQ, 32'h8000_0000, 1'b0); settle();
    check("dflt_os_hsel", {30'b0, bus.os_hsel}, 32'h0);
    check("dflt_os_htrans", {28'b0, bus.os_htrans}, 32'h0);
    check("dflt_om_hready1_a", {31'b0, bus.om_hready[1]}, 32'h1);
    tick(); drive(1, IDLE, 32'h0, 1'b0); settle();
    check("dflt_err1_hready", {30'b0, bus.om_hready}, 32'h1);
    check("dflt_err1_hresp1", {30'b0, bus.om_hresp[3:2]}, 32'h1);
    tick(); settle();
    check("dflt_err2_hready1", {31'b0, bus.om_hready[1]}, 32'h1);
    check("dflt_err2_hresp1", {30'b0, bus.om_hresp[3:2]}, 32'h1);
    tick(); settle();
    check("dflt_done_hresp1", {30'b0, bus.om_hresp[3:2]}, 32'h0);

    // Route bit cleared: master0 to slave0's window falls to the default slave
    tick(); bus.im_route = 4'b1110; drive(0, NSEQ, 32'h0000_0010, 1'b0); settle();
    check("route_os_hsel", {30'b0, bus.os_hsel}, 32'h0);
    tick(); drive(0, IDLE, 32'h0, 1'b0); settle();
    check("route_err1_hready0", {31'b0, bus.om_hready[0]}, 32'h0);
    check("route_err1_hresp0", {30'b0, bus.om_hresp[1:0]}, 32'h1);
    tick(); settle();
    check("route_err2_hready0", {31'b0, bus.om_hready[0]}, 32'h1);
    check("route_err2_hresp0", {30'b0, bus.om_hresp[1:0]}, 32'h1);
    tick(); bus.im_route = 4'b1111;

    // Slave0 wait states: master0 data phase and master1 address both stall for 3 cycles
    tick(); drive(0, NSEQ, 32'h0000_0040, 1'b0); settle();
    check("ws_accept_hready0", {31'b0, bus.om_hready[0]}, 32'h1);
    tick(); drive(0, IDLE, 32'h0, 1'b0); drive(1, NSEQ, 32'h0000_0044, 1'b0); bus.is_hready[0] = 1'b0; settle();
    check("ws_c1_hready", {30'b0, bus.om_hready}, 32'h0);
    check("ws_c1_os_haddr0", bus.os_haddr[31:0], 32'h0000_0044);
    tick(); settle();
    check("ws_c2_hready", {30'b0, bus.om_hready}, 32'h0);
    tick(); settle();
    check("ws_c3_hready", {30'b0, bus.om_hready}, 32'h0);
    tick(); bus.is_hready[0] = 1'b1; settle();
    check("ws_c4_hready", {30'b0, bus.om_hready}, 32'h3);
    tick(); drive(1, IDLE, 32'h0, 1'b0); settle();
    check("ws_m1_data_hready", {30'b0, bus.om_hready}, 32'h3);

    // Burst lock: master1 keeps slave0 through SEQ despite higher-priority master0
    tick(); drive(1, NSEQ, 32'h0000_0050, 1'b0); settle();
    check("lock_os_haddr0_a", bus.os_haddr[31:0], 32'h0000_0050);
    tick(); drive(1, SEQ, 32'h0000_0054, 1'b0); drive(0, NSEQ, 32'h0000_0060, 1'b0); settle();
    check("lock_os_haddr0_b", bus.os_haddr[31:0], 32'h0000_0054);
    check("lock_om_hready_b", {30'b0, bus.om_hready}, 32'h2);
    tick(); drive(1, IDLE, 32'h0, 1'b0); settle();
    check("lock_os_haddr0_c", bus.os_haddr[31:0], 32'h0000_0060);
    check("lock_om_hready_c", {30'b0, bus.om_hready}, 32'h3);
    tick(); drive(0, IDLE, 32'h0, 1'b0);

    // Reset mid-burst: everything abandoned on the next edge even with masters still driving SEQ
    tick(); drive(0, NSEQ, 32'h1000_0000, 1'b0); drive(1, NSEQ, 32'h0000_0000, 1'b0); settle();
    check("brst_os_hsel", {30'b0, bus.os_hsel}, 32'h3);
    tick(); drive(0, SEQ, 32'h1000_0004, 1'b0); drive(1, SEQ, 32'h0000_0004, 1'b0); hreset = 1'b1;
    tick(); settle();
    check("mrst_om_hready", {30'b0, bus.om_hready}, 32'h3);
    check("mrst_os_hsel", {30'b0, bus.os_hsel}, 32'h0);
    check("mrst_os_htrans", {28'b0, bus.os_htrans}, 32'h0);
    check("mrst_om_hresp", {28'b0, bus.om_hresp}, 32'h0);
    tick(); hreset = 1'b0; drive(0, IDLE, 32'h0, 1'b0); drive(1, IDLE, 32'h0, 1'b0);
    tick(); settle();
    check("post_rst_om_hready", {30'b0, bus.om_hready}, 32'h3);
    check("post_rst_os_hwdata", bus.os_hwdata[63:32], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
